// File: rtl/sddr_cmd_monitor.sv
// Passive DDR3 command-bus monitor: decodes commands, tracks per-bank state,
// flags ordering/spacing violations and exposes results via a register window.
module sddr_cmd_monitor #(
  parameter int BANK_BITS = 3,
  parameter int ROW_BITS  = 13,
  parameter int T_RCD     = 6,
  parameter int T_RP      = 6,
  parameter int T_RFC     = 64
) (
  input  logic                 cpu_clock_i,
  input  logic                 cpu_reset_i,
  input  logic                 ddr3_reset_n_i,
  input  logic                 ddr3_cke_i,
  input  logic                 ddr3_cs_n_i,
  input  logic                 ddr3_ras_n_i,
  input  logic                 ddr3_cas_n_i,
  input  logic                 ddr3_we_n_i,
  input  logic [BANK_BITS-1:0] ddr3_ba_i,
  input  logic [ROW_BITS-1:0]  ddr3_addr_i,
  input  logic                 ctrl_cmd_valid,
  input  logic [15:0]          ctrl_cmd_address,
  input  logic [31:0]          ctrl_cmd_data,
  input  logic                 ctrl_cmd_write,
  output logic                 ctrl_cmd_ack,
  output logic                 ctrl_rsp_ready,
  output logic [31:0]          ctrl_rsp_data,
  output logic                 error_o
);

  localparam int NB     = 1 << BANK_BITS;
  localparam int T_MAX0 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_MAX  = (T_MAX0 > T_RFC) ? T_MAX0 : T_RFC;
  localparam int TW     = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] T_SAT   = TW'(T_MAX);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_RCD_W = TW'(T_RCD);
  localparam logic [TW-1:0] T_RP_W  = TW'(T_RP);
  localparam logic [TW-1:0] T_RFC_W = TW'(T_RFC);

  typedef enum logic [3:0] {
    CMD_MRS = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_ZQC = 4'b0110,
    CMD_NOP = 4'b0111
  } cmd_e;

  logic [3:0]                    cmd_bits;
  logic                          is_idle, is_act, is_pre, is_rd, is_wr, is_ref;
  logic [NB-1:0]                 act_hit, pre_hit;
  logic [NB-1:0]                 bank_open;
  logic [NB-1:0][ROW_BITS-1:0]   open_row;
  logic [NB-1:0][TW-1:0]         act_timer, pre_timer;
  logic [TW-1:0]                 ref_timer;
  logic [7:0]                    viol;
  logic [7:0]                    status, status_next;
  logic [31:0]                   capture, capture_value;
  logic [31:0]                   act_count, rd_count, wr_count, ref_count;
  logic [31:0]                   rd_value;
  logic                          wr_en, rd_en;
  logic                          unused_bits;

  assign cmd_bits = {ddr3_cs_n_i, ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i};

  always_comb begin
    is_idle = ddr3_cs_n_i || (cmd_bits == CMD_NOP);
    is_act  = !ddr3_cs_n_i && (cmd_bits == CMD_ACT);
    is_pre  = !ddr3_cs_n_i && (cmd_bits == CMD_PRE);
    is_rd   = !ddr3_cs_n_i && (cmd_bits == CMD_RD);
    is_wr   = !ddr3_cs_n_i && (cmd_bits == CMD_WR);
    is_ref  = !ddr3_cs_n_i && (cmd_bits == CMD_REF);
  end

  always_comb begin
    act_hit = '0;
    pre_hit = '0;
    for (int b = 0; b < NB; b++) begin
      act_hit[b] = is_act && (ddr3_ba_i == BANK_BITS'(b));
      pre_hit[b] = is_pre && (ddr3_addr_i[10] || (ddr3_ba_i == BANK_BITS'(b)));
    end
  end

  // Timers hold "edges since event", so the value seen at a command edge is k.
  always_comb begin
    viol = '0;
    if (is_act) begin
      viol[0] = bank_open[ddr3_ba_i];
      viol[3] = pre_timer[ddr3_ba_i] < T_RP_W;
    end
    if (is_rd || is_wr) begin
      viol[1] = !bank_open[ddr3_ba_i];
      viol[2] = act_timer[ddr3_ba_i] < T_RCD_W;
    end
    if (is_ref) begin
      viol[4] = |bank_open;
    end
    if (!is_idle) begin
      viol[5] = ref_timer < T_RFC_W;
      viol[6] = !ddr3_cke_i;
      viol[7] = !ddr3_reset_n_i;
    end
  end

  assign wr_en = ctrl_cmd_valid && ctrl_cmd_write;
  assign rd_en = ctrl_cmd_valid && !ctrl_cmd_write;

  // New violations are OR-ed in after the W1C mask so they always survive.
  always_comb begin
    status_next = status;
    if (wr_en && (ctrl_cmd_address == 16'h0000)) begin
      status_next = status & ~ctrl_cmd_data[7:0];
    end
    status_next = status_next | viol;
  end

  always_comb begin
    capture_value                  = '0;
    capture_value[19:16]           = cmd_bits;
    capture_value[8 +: BANK_BITS]  = ddr3_ba_i;
    capture_value[7:0]             = viol;
  end

  always_comb begin
    rd_value = '0;
    case (ctrl_cmd_address)
      16'h0000: rd_value = {24'd0, status};
      16'h0004: rd_value = 32'(bank_open);
      16'h0008: rd_value = act_count;
      16'h000C: rd_value = rd_count;
      16'h0010: rd_value = wr_count;
      16'h0014: rd_value = ref_count;
      16'h0018: rd_value = capture;
      default:  rd_value = '0;
    endcase
  end

  function automatic logic [31:0] count_next(input logic [31:0] cnt,
                                             input logic        clr,
                                             input logic        inc);
    logic [31:0] base;
    base = clr ? 32'd0 : cnt;
    if (inc && (base != 32'hFFFF_FFFF)) begin
      base = base + 32'd1;
    end
    return base;
  endfunction

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      bank_open <= '0;
      open_row  <= '0;
      act_timer <= {NB{T_SAT}};
      pre_timer <= {NB{T_SAT}};
      ref_timer <= T_SAT;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (act_hit[b]) begin
          bank_open[b] <= 1'b1;
          open_row[b]  <= ddr3_addr_i;
          act_timer[b] <= T_ONE;
        end else if (act_timer[b] != T_SAT) begin
          act_timer[b] <= act_timer[b] + T_ONE;
        end
        if (pre_hit[b]) begin
          bank_open[b] <= 1'b0;
          pre_timer[b] <= T_ONE;
        end else if (pre_timer[b] != T_SAT) begin
          pre_timer[b] <= pre_timer[b] + T_ONE;
        end
      end
      if (is_ref) begin
        ref_timer <= T_ONE;
      end else if (ref_timer != T_SAT) begin
        ref_timer <= ref_timer + T_ONE;
      end
    end
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      act_count <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      ref_count <= '0;
    end else begin
      act_count <= count_next(act_count, wr_en && (ctrl_cmd_address == 16'h0008), is_act);
      rd_count  <= count_next(rd_count,  wr_en && (ctrl_cmd_address == 16'h000C), is_rd);
      wr_count  <= count_next(wr_count,  wr_en && (ctrl_cmd_address == 16'h0010), is_wr);
      ref_count <= count_next(ref_count, wr_en && (ctrl_cmd_address == 16'h0014), is_ref);
    end
  end

  // Capture only the first violation after status was last fully clear.
  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      status         <= '0;
      capture        <= '0;
      error_o        <= 1'b0;
      ctrl_rsp_ready <= 1'b0;
      ctrl_rsp_data  <= '0;
    end else begin
      status  <= status_next;
      error_o <= |status_next;
      if ((status == 8'd0) && (viol != 8'd0)) begin
        capture <= capture_value;
      end
      ctrl_rsp_ready <= rd_en;
      ctrl_rsp_data  <= rd_en ? rd_value : 32'd0;
    end
  end

  assign ctrl_cmd_ack = 1'b1;

  // Open rows are tracked for debug visibility but feed no check or register.
  assign unused_bits = ^{open_row, ctrl_cmd_data[31:8]};

endmodule
